grf_mp: RTL and testbench

Multi-port general register file for the pipelined MIPS core, replacing the fixed 2-read/1-write GRF. Width, depth, and read/write port counts are parameters, so dual-issue and multi-writeback variants can use it. Same-cycle write-to-read bypass is built in. A per-register pending-write scoreboard lets decode stall on RAW hazards without a separate hazard table. It sits between the ID stage (reads, issue) and the WB stage(s) (writes).

---
 rtl/grf_pkg.sv | 15 +
 rtl/grf_scoreboard.sv | 70 +++++++
 rtl/grf_mp.sv | 92 +++++++++
 tb/tb_grf_mp.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
// Shared GRF constants: default widths and scoreboard counter limits,
// also used by the hazard and forwarding units.
package grf_pkg;

  localparam int unsigned GRF_DATA_W  = 32;
  localparam int unsigned GRF_ADDR_W  = 5;
  localparam int unsigned GRF_PEND_W  = 2;
  localparam int unsigned GRF_CNT_MAX = (32'd1 << GRF_PEND_W) - 32'd1;

  // Largest outstanding-write count a PEND_W-bit counter can hold.
  function automatic int unsigned pend_max(input int unsigned pend_w);
    return (32'd1 << pend_w) - 32'd1;
  endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// Per-register pending-write counters: retire on writeback, count up on issue,
// and report read-port busy and issue stall.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int unsigned ADDR_W   = GRF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned PEND_W   = GRF_PEND_W,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_WR-1:0]          wr_eff,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD-1:0]          rd_busy,
  output logic                       iss_stall
);

  localparam int unsigned       DEPTH   = 32'd1 << ADDR_W;
  localparam logic [PEND_W-1:0] CNT_MAX = PEND_W'(pend_max(PEND_W));

  logic [PEND_W-1:0] cnt_q [DEPTH];
  logic [PEND_W-1:0] cnt_d [DEPTH];
  logic [PEND_W-1:0] post  [DEPTH];
  logic              inc;

  // Retire this cycle's writebacks, saturating at zero for untracked writes.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      post[r] = cnt_q[r];
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_eff[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r)) && (post[r] != '0)) begin
          post[r] = post[r] - PEND_W'(1);
        end
      end
    end
  end

  always_comb begin
    iss_stall = 1'b0;
    inc       = 1'b0;
    rd_busy   = '0;
    iss_stall = !reset && iss_en && (post[iss_addr] == CNT_MAX);
    inc       = !reset && iss_en && !iss_stall && !(ZERO_REG && (iss_addr == '0));
    for (int r = 0; r < DEPTH; r++) begin
      cnt_d[r] = post[r];
      if (inc && (iss_addr == ADDR_W'(r))) begin
        cnt_d[r] = post[r] + PEND_W'(1);
      end
    end
    for (int i = 0; i < NUM_RD; i++) begin
      rd_busy[i] = !reset
                && (post[rd_addr[i*ADDR_W +: ADDR_W]] != '0)
                && !(ZERO_REG && (rd_addr[i*ADDR_W +: ADDR_W] == '0));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) cnt_q[r] <= cnt_d[r];
    end
  end

endmodule

// File: rtl/grf_mp.sv
// Multi-port general register file with same-cycle write-to-read bypass
// and a pending-write scoreboard for RAW stall detection.
module grf_mp
  import grf_pkg::*;
#(
  parameter int unsigned DATA_W   = GRF_DATA_W,
  parameter int unsigned ADDR_W   = GRF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned PEND_W   = GRF_PEND_W,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  output logic                       iss_stall
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  logic [NUM_WR-1:0] wr_eff;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    wr_eff = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wr_eff[j] = wr_en[j] && !(ZERO_REG && (wr_addr[j*ADDR_W +: ADDR_W] == '0));
    end
  end

  // Later ports overwrite earlier ones, so the highest-index writer wins.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) mem_d[r] = mem_q[r];
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_eff[j]) begin
        mem_d[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= mem_d[r];
    end
  end

  // Read mux: array, then bypass from the highest matching writer, then zero register.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data[i*DATA_W +: DATA_W] = mem_q[rd_addr[i*ADDR_W +: ADDR_W]];
      for (int j = 0; j < NUM_WR; j++) begin
        if (!reset && wr_eff[j]
            && (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W])) begin
          rd_data[i*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
        end
      end
      if (ZERO_REG && (rd_addr[i*ADDR_W +: ADDR_W] == '0)) begin
        rd_data[i*DATA_W +: DATA_W] = '0;
      end
    end
  end

  grf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .PEND_W   (PEND_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .wr_eff    (wr_eff),
    .wr_addr   (wr_addr),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy),
    .iss_stall (iss_stall)
  );

endmodule

// File: tb/tb_grf_mp.sv
// Bench for grf_mp: directed vector table for the hazard/bypass corners,
// then randomized traffic checked against a simple array-and-counter model.
module tb_grf_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [2*AW-1:0] rd_addr;
  logic [2*DW-1:0] rd_data;
  logic [1:0]    rd_busy;
  logic [1:0]    wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic          iss_en;
  logic [AW-1:0] iss_addr;
  logic          iss_stall;

  grf_mp dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .iss_stall (iss_stall)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_regs [32];
  int          m_cnt  [32];

  typedef struct {
    logic        rst;
    logic [1:0]  we;
    int          wa0;
    logic [31:0] wd0;
    int          wa1;
    logic [31:0] wd1;
    logic        ie;
    int          ia;
    int          ra0;
    int          ra1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_busy;
    logic        e_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [1:0] we,
                              input int wa0, input logic [31:0] wd0,
                              input int wa1, input logic [31:0] wd1,
                              input logic ie, input int ia,
                              input int ra0, input int ra1,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [1:0] eb, input logic es);
    vec_t v;
    v.rst = rst; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ie = ie; v.ia = ia; v.ra0 = ra0; v.ra1 = ra1;
    v.e_rd0 = e0; v.e_rd1 = e1; v.e_busy = eb; v.e_stall = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int waddr(input int j);
    return int'(wr_addr[j*AW +: AW]);
  endfunction

  function automatic int raddr(input int i);
    return int'(rd_addr[i*AW +: AW]);
  endfunction

  // Outstanding count of r once this cycle's writebacks are retired.
  function automatic int m_post(input int r);
    int n = 0;
    for (int j = 0; j < 2; j++)
      if (wr_en[j] && waddr(j) != 0 && waddr(j) == r) n++;
    return (n > m_cnt[r]) ? 0 : m_cnt[r] - n;
  endfunction

  function automatic logic [31:0] m_read(input int i);
    int a = raddr(i);
    logic [31:0] d;
    if (a == 0) return 32'h0;
    d = m_regs[a];
    if (!reset)
      for (int j = 0; j < 2; j++)
        if (wr_en[j] && waddr(j) == a) d = wr_data[j*DW +: DW];
    return d;
  endfunction

  function automatic logic m_stall();
    return !reset && iss_en && (m_post(int'(iss_addr)) == 3);
  endfunction

  function automatic logic [1:0] m_busy();
    logic [1:0] b;
    for (int i = 0; i < 2; i++)
      b[i] = !reset && raddr(i) != 0 && m_post(raddr(i)) != 0;
    return b;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = 32'h0;
      m_cnt[r]  = 0;
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic m_clock();
    int post [32];
    logic st;
    st = m_stall();
    if (reset) begin
      m_reset();
    end else begin
      for (int r = 0; r < 32; r++) post[r] = m_post(r);
      for (int j = 0; j < 2; j++)
        if (wr_en[j] && waddr(j) != 0) m_regs[waddr(j)] = wr_data[j*DW +: DW];
      for (int r = 0; r < 32; r++) m_cnt[r] = post[r];
      if (iss_en && !st && iss_addr != 0) m_cnt[iss_addr]++;
    end
  endtask

  task automatic apply(input vec_t v);
    reset    = v.rst;
    wr_en    = v.we;
    wr_addr  = {AW'(v.wa1), AW'(v.wa0)};
    wr_data  = {v.wd1, v.wd0};
    iss_en   = v.ie;
    iss_addr = AW'(v.ia);
    rd_addr  = {AW'(v.ra1), AW'(v.ra0)};
  endtask

  initial begin
    reset = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; rd_addr = '0;

    //        rst we    wa0 wd0            wa1 wd1            ie ia ra0 ra1 e_rd0          e_rd1          busy   stall
    vecs.push_back(mk(0, 2'b00, 0, 32'h0,          0, 32'h0,          0, 0, 5, 5, 32'h0,         32'h0,         2'b00, 0));
    vecs.push_back(mk(0, 2'b11, 5, 32'h1111_1111,  5, 32'h2222_2222,  0, 0, 5, 0, 32'h2222_2222, 32'h0,         2'b00, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0,          0, 32'h0,          0, 0, 5, 5, 32'h2222_2222, 32'h2222_2222, 2'b00, 0));
    vecs.push_back(mk(0, 2'b01, 0, 32'hDEAD_BEEF,  0, 32'h0,          1, 0, 0, 0, 32'h0,         32'h0,         2'b00, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0,          0, 32'h0,          0, 0, 0, 0, 32'h0,         32'h0,         2'b00, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0,          0, 32'h0,          1, 7, 7, 7, 32'h0,         32'h0,         2'b00, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0,          0, 32'h0,          1, 7, 7, 7, 32'h0,         32'h0,         2'b11, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0,          0, 32'h0,          1, 7, 7, 7, 32'h0,         32'h0,         2'b11, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0,          0, 32'h0,          1, 7, 7, 7, 32'h0,         32'h0,         2'b11, 1));
    vecs.push_back(mk(0, 2'b01, 7, 32'h0000_0077,  0, 32'h0,          1, 7, 7, 7, 32'h77,        32'h77,        2'b11, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0,          0, 32'h0,          1, 7, 7, 7, 32'h77,        32'h77,        2'b11, 1));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0,          7, 32'h0000_0070,  0, 0, 7, 7, 32'h70,        32'h70,        2'b11, 0));
    vecs.push_back(mk(0, 2'b11, 7, 32'h0000_0071,  7, 32'h0000_0072,  0, 0, 7, 7, 32'h72,        32'h72,        2'b00, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0,          0, 32'h0,          0, 0, 7, 9, 32'h72,        32'h0,         2'b00, 0));
    vecs.push_back(mk(0, 2'b01, 9, 32'h0000_0099,  0, 32'h0,          0, 0, 9, 7, 32'h99,        32'h72,        2'b00, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0,          0, 32'h0,          0, 0, 9, 9, 32'h99,        32'h99,        2'b00, 0));
    vecs.push_back(mk(0, 2'b01, 3, 32'h0000_00AB,  0, 32'h0,          1, 3, 3, 9, 32'hAB,        32'h99,        2'b00, 0));
    vecs.push_back(mk(1, 2'b01, 3, 32'h0000_00FF,  0, 32'h0,          1, 3, 3, 9, 32'hAB,        32'h99,        2'b00, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0,          0, 32'h0,          0, 0, 3, 9, 32'h0,         32'h0,         2'b00, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0,          0, 32'h0,          1, 3, 3, 3, 32'h0,         32'h0,         2'b00, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0,          0, 32'h0,          0, 0, 3, 3, 32'h0,         32'h0,         2'b11, 0));

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_reset();

    // Post-reset sweep of every register on both read ports.
    for (int a = 0; a < 32; a += 2) begin
      rd_addr = {AW'(a + 1), AW'(a)};
      @(negedge clk);
      chk($sformatf("reset_rd a=%0d", a), 64'(rd_data), 64'h0);
      chk($sformatf("reset_busy a=%0d", a), 64'(rd_busy), 64'h0);
      m_clock();
      @(posedge clk);
      #1;
    end

    foreach (vecs[k]) begin
      apply(vecs[k]);
      @(negedge clk);
      chk($sformatf("row%0d rd0", k),   64'(rd_data[31:0]),  64'(vecs[k].e_rd0));
      chk($sformatf("row%0d rd1", k),   64'(rd_data[63:32]), 64'(vecs[k].e_rd1));
      chk($sformatf("row%0d busy", k),  64'(rd_busy),        64'(vecs[k].e_busy));
      chk($sformatf("row%0d stall", k), 64'(iss_stall),      64'(vecs[k].e_stall));
      m_clock();
      @(posedge clk);
      #1;
    end

    for (int c = 0; c < 800; c++) begin
      reset    = ($urandom_range(0, 59) == 0);
      wr_en    = 2'($urandom_range(0, 3));
      wr_addr  = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      wr_data  = {$urandom, $urandom};
      iss_en   = ($urandom_range(0, 2) != 0);
      iss_addr = AW'($urandom_range(0, 7));
      rd_addr  = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      @(negedge clk);
      chk($sformatf("rnd%0d rd0", c),   64'(rd_data[31:0]),  64'(m_read(0)));
      chk($sformatf("rnd%0d rd1", c),   64'(rd_data[63:32]), 64'(m_read(1)));
      chk($sformatf("rnd%0d busy", c),  64'(rd_busy),        64'(m_busy()));
      chk($sformatf("rnd%0d stall", c), 64'(iss_stall),      64'(m_stall()));
      m_clock();
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
